// File: rtl/mealy_ctx_sched.sv
// rtl/mealy_ctx_sched.sv - round-robin time-multiplexed 2-bit Mealy transducer with per-channel context
// Optional per-channel grant counters are enabled with MEALY_SCHED_STATS_EN.
module mealy_ctx_sched #(
  parameter int N_CH  = 4,
  parameter int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  in_valid,
  input  logic [N_CH-1:0]  in_a,
  input  logic [N_CH-1:0]  in_b,
  output logic [N_CH-1:0]  in_ready,
  input  logic [N_CH-1:0]  ctx_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CH_W-1:0]  out_ch,
  output logic [1:0]       out_y,
  output logic [1:0]       out_s,
`ifdef MEALY_SCHED_STATS_EN
  input  logic [CH_W-1:0]  stat_sel,
  output logic [CNT_W-1:0] stat_cnt,
`endif
  output logic             busy
);

  localparam logic [CH_W:0]   N_CH_EXT = (CH_W + 1)'(N_CH);
  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(N_CH - 1);

  logic [1:0]      ctx [N_CH];
  logic [CH_W-1:0] rr_ptr;

  logic            accept;
  logic            found;
  logic            grant;
  logic [CH_W-1:0] gnt_idx;
  logic [CH_W:0]   idx_w;

  logic [1:0]      s_eff;
  logic            sym_a;
  logic            sym_b;
  logic [1:0]      y;
  logic [1:0]      n;

  assign accept = ~out_valid | out_ready;

  // Rotating-priority search: first requester at or after rr_ptr, wrapping at N_CH.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    idx_w   = '0;
    for (int k = 0; k < N_CH; k++) begin
      idx_w = {1'b0, rr_ptr} + (CH_W + 1)'(k);
      if (idx_w >= N_CH_EXT) begin
        idx_w = idx_w - N_CH_EXT;
      end
      if (!found && in_valid[idx_w[CH_W-1:0]]) begin
        found   = 1'b1;
        gnt_idx = idx_w[CH_W-1:0];
      end
    end
  end

  assign grant = found & accept & ~rst;

  always_comb begin
    in_ready = '0;
    if (grant) begin
      in_ready[gnt_idx] = 1'b1;
    end
  end

  // A same-cycle clear wins over the stored context for the symbol being processed.
  always_comb begin
    s_eff = ctx_clr[gnt_idx] ? 2'b00 : ctx[gnt_idx];
    sym_a = in_a[gnt_idx];
    sym_b = in_b[gnt_idx];
    y[0]  = (~sym_a & sym_b) | (s_eff[1] & s_eff[0]) | (s_eff[1] & sym_b);
    y[1]  = (~s_eff[1] & sym_a) | (~s_eff[0] & ~sym_b & sym_a);
    n[1]  = y[1];
    n[0]  = (~s_eff[0] & sym_b) | (s_eff[1] & s_eff[0]) | (s_eff[1] & sym_b);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        ctx[i] <= 2'b00;
      end
      rr_ptr    <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_y     <= 2'b00;
      out_s     <= 2'b00;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (grant && gnt_idx == CH_W'(i)) begin
          ctx[i] <= n;
        end else if (ctx_clr[i]) begin
          ctx[i] <= 2'b00;
        end
      end
      if (grant) begin
        out_valid <= 1'b1;
        out_ch    <= gnt_idx;
        out_y     <= y;
        out_s     <= n;
        rr_ptr    <= (gnt_idx == LAST_CH) ? '0 : gnt_idx + CH_W'(1);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign busy = (|in_valid) | out_valid;

`ifdef MEALY_SCHED_STATS_EN
  logic [CNT_W-1:0] cnt [N_CH];

  // Clear precedes increment, so a cleared-and-granted channel reads 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (ctx_clr[i]) begin
          cnt[i] <= (grant && gnt_idx == CH_W'(i)) ? CNT_W'(1) : '0;
        end else if (grant && gnt_idx == CH_W'(i)) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    stat_cnt = '0;
    if ({1'b0, stat_sel} < N_CH_EXT) begin
      stat_cnt = cnt[stat_sel];
    end
  end
`endif

endmodule

// File: tb/tb_mealy_ctx_sched.sv
// tb/tb_mealy_ctx_sched.sv - directed self-checking bench for mealy_ctx_sched
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_mealy_ctx_sched;

  localparam int N_CH = 4;
  localparam int CH_W = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N_CH-1:0] in_valid;
  logic [N_CH-1:0] in_a;
  logic [N_CH-1:0] in_b;
  logic [N_CH-1:0] in_ready;
  logic [N_CH-1:0] ctx_clr;
  logic            out_valid;
  logic            out_ready;
  logic [CH_W-1:0] out_ch;
  logic [1:0]      out_y;
  logic [1:0]      out_s;
  logic            busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mealy_ctx_sched #(.N_CH(N_CH), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_ready(in_ready),
    .ctx_clr(ctx_clr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ch(out_ch), .out_y(out_y), .out_s(out_s),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] clr);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    ctx_clr  = clr;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [1:0] ch,
                         input logic [1:0] y, input logic [1:0] s);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    if (v) begin
      chk({tag, ".ch"}, 32'(out_ch), 32'(ch));
      chk({tag, ".y"},  32'(out_y),  32'(y));
      chk({tag, ".s"},  32'(out_s),  32'(s));
    end
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    drive(4'b1111, 4'b1111, 4'b0000, 4'b0000);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    tick();
    tick();
    chk("rst_in_ready2", 32'(in_ready), 32'h0);
    chk("rst_busy_in", 32'(busy), 32'h1);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_ch", 32'(out_ch), 32'h0);
    chk("rst_out_y", 32'(out_y), 32'h0);
    chk("rst_out_s", 32'(out_s), 32'h0);
    drive(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    rst = 1'b0;
    #1;
    chk("idle_busy", 32'(busy), 32'h0);
    chk("idle_in_ready", 32'(in_ready), 32'h0);

    // Single channel, back-to-back symbols
    drive(4'b0001, 4'b0001, 4'b0000, 4'b0000); #1;
    chk("sc0_in_ready", 32'(in_ready), 32'h1);
    tick(); chk_out("sc0", 1, 0, 2'b10, 2'b10);
    drive(4'b0001, 4'b0000, 4'b0001, 4'b0000); #1;
    chk("sc1_in_ready", 32'(in_ready), 32'h1);
    tick(); chk_out("sc1", 1, 0, 2'b01, 2'b01);
    drive(4'b0001, 4'b0001, 4'b0001, 4'b0000);
    tick(); chk_out("sc2", 1, 0, 2'b10, 2'b10);
    chk("sc2_busy", 32'(busy), 32'h1);
    drive(4'b0000, 4'b0000, 4'b0000, 4'b1111);
    tick(); chk_out("sc_drain", 0, 0, 0, 0);

    // Context isolation between ch0 and ch1
    drive(4'b0001, 4'b0001, 4'b0000, 4'b0000);
    tick(); chk_out("iso0", 1, 0, 2'b10, 2'b10);
    drive(4'b0010, 4'b0000, 4'b0010, 4'b0000);
    tick(); chk_out("iso1", 1, 1, 2'b01, 2'b01);
    drive(4'b0001, 4'b0000, 4'b0001, 4'b0000);
    tick(); chk_out("iso2", 1, 0, 2'b01, 2'b01);

    // Round-robin from a fresh reset
    drive(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(4'b1111, 4'b1111, 4'b0000, 4'b0000);
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("rr%0d_in_ready", i), 32'(in_ready), 32'(4'b0001 << (i % 4)));
      tick();
      chk_out($sformatf("rr%0d", i), 1, 2'(i % 4), 2'b10, 2'b10);
    end

    // Backpressure holding a ch0 result
    tick(); chk_out("bp_first", 1, 0, 2'b10, 2'b10);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp%0d_in_ready", i), 32'(in_ready), 32'h0);
      tick();
      chk_out($sformatf("bp%0d", i), 1, 0, 2'b10, 2'b10);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rel_in_ready", 32'(in_ready), 32'h2);
    tick(); chk_out("bp_rel1", 1, 1, 2'b10, 2'b10);
    tick(); chk_out("bp_rel2", 1, 2, 2'b10, 2'b10);
    drive(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick(); chk_out("bp_drain", 0, 0, 0, 0);

    // Clear collides with a ch2 grant; ctx2 was 10
    drive(4'b0100, 4'b0000, 4'b0100, 4'b0100); #1;
    chk("cc_in_ready", 32'(in_ready), 32'h4);
    tick(); chk_out("cc", 1, 2, 2'b01, 2'b01);
    drive(4'b0100, 4'b0100, 4'b0100, 4'b0000);
    tick(); chk_out("cc_follow", 1, 2, 2'b10, 2'b10);

    // Clear without grant on ch3 (ctx3 was 10)
    drive(4'b0000, 4'b0000, 4'b0000, 4'b1000);
    tick(); chk_out("clr_idle", 0, 0, 0, 0);
    drive(4'b1000, 4'b1000, 4'b1000, 4'b0000);
    tick(); chk_out("clr_ch3", 1, 3, 2'b10, 2'b11);

    // Reset while a result is held
    drive(4'b0001, 4'b0001, 4'b0000, 4'b0000);
    tick(); chk_out("mr_pre", 1, 0, 2'b10, 2'b10);
    drive(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    out_ready = 1'b0;
    rst = 1'b1;
    tick();
    chk("mr_out_valid", 32'(out_valid), 32'h0);
    chk("mr_out_y", 32'(out_y), 32'h0);
    rst = 1'b0;
    out_ready = 1'b1;
    drive(4'b0001, 4'b0001, 4'b0000, 4'b0000);
    tick(); chk_out("mr_ch0", 1, 0, 2'b10, 2'b10);
    drive(4'b1000, 4'b1000, 4'b1000, 4'b0000);
    tick(); chk_out("mr_ch3", 1, 3, 2'b10, 2'b11);
    drive(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick(); chk_out("end_drain", 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
